parallax_scroll_scheduler: RTL and testbench
============================================

Name: parallax_scroll_scheduler

Overview:
Per-frame scroll scheduler for the multi-layer parallax background. It detects the vsync rising edge and advances NUM_LAYERS independent layer offsets, one layer per clock, through a single shared add/wrap unit. It runs a game-level state machine (idle/run/paused/halted) that gates scrolling. Its outputs feed the background pixel-address generators in place of per-layer free-running scroll counters.

Parameters:
NUM_LAYERS, 3, number of parallax layers (1..8)
OFFSET_W, 10, width of each layer offset
SCROLL_PERIOD, 512, offset modulus; must be <= 2**OFFSET_W and > max speed
LEVEL_W, 2, width of the speed-level input

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vsync  in  1  active-high vsync, synchronous to clk
start  in  1  one-cycle pulse: begin or restart scrolling
pause_toggle  in  1  one-cycle pulse: toggle run/pause
halt  in  1  level: game over, freeze scrolling
level  in  LEVEL_W  speed level, sampled once per frame
layer_offset  out  NUM_LAYERS*OFFSET_W  packed offsets, layer k at bits [k*OFFSET_W +: OFFSET_W]
update_busy  out  1  sweep in progress
frame_done  out  1  one-cycle pulse after the last layer updates
state  out  2  0=IDLE 1=RUN 2=PAUSED 3=HALTED

Behaviour:
- Reset values: all offsets 0, state IDLE, update_busy 0, frame_done 0, vsync_q 0, pending pause 0.
- Edge detect: vsync_q registers vsync. Edge cycle E is any cycle with vsync=1 and vsync_q=0.
- Speed of layer k: (k+1) + level_q, where level_q is level latched in cycle E. All sums are OFFSET_W+1 bits wide; there is no overflow.
- Wrap: if offset+speed >= SCROLL_PERIOD, then new = offset+speed-SCROLL_PERIOD (true modulo). Otherwise new = offset+speed.
- Sweep: starts on an edge in RUN with update_busy=0.
  - At the end of cycle E: update_busy<=1, idx<=0.
  - Layer k is written at the end of cycle E+1+k.
  - After the write of layer NUM_LAYERS-1: update_busy<=0, and frame_done is high for exactly cycle E+NUM_LAYERS+1.
  - Offsets change only during a sweep, or on start from HALTED.
- Edge while update_busy=1: ignored, no queueing.
- Edge in IDLE, PAUSED or HALTED: ignored.
- State transitions (priority halt > pause_toggle > start):
  - IDLE: start -> RUN.
  - RUN: halt -> HALTED. pause_toggle -> PAUSED. If update_busy=1, pause_toggle sets pending_pause instead; the sweep completes with frame_done, and the state becomes PAUSED in the cycle after frame_done.
  - PAUSED: pause_toggle -> RUN. halt -> HALTED.
  - HALTED: stays while halt=1. start with halt=0 -> all offsets cleared to 0 and state RUN in the same edge.
- halt mid-sweep: the sweep aborts immediately. Layers already written keep their new values; unwritten layers are unchanged. update_busy<=0, no frame_done, pending_pause cleared.
- start in RUN or PAUSED: ignored. pause_toggle in IDLE or HALTED: ignored.
- Simultaneous edge and halt in RUN: halt wins, no sweep starts.
- Reset mid-sweep: all registers return to reset values on the next edge.
- state output equals the registered state; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, start, one vsync edge (level=0, N=3) -> offsets 1,2,3; update_busy high cycles E+1..E+3; frame_done high only in cycle E+4.
- Preload layer 2 to 510 via 170 frames at level 0, then one more frame -> layer 2 = 1 (513-512); layers 0,1 = 171, 342.
- level=3 for one frame from zero -> offsets 4,5,6. Change level mid-sweep to 0 -> speeds for that frame stay 4,5,6.
- pause_toggle in cycle E+2 -> sweep completes, frame_done pulses, state=PAUSED next cycle. Further edges leave offsets unchanged. pause_toggle -> RUN, next edge resumes.
- halt asserted in cycle E+2 (N=3) -> layers 0,1 updated, layer 2 unchanged, no frame_done, state=HALTED. Release halt, start -> offsets 0,0,0, state=RUN.
- vsync held high for 10 cycles, then edge during a sweep and edge in IDLE -> exactly one sweep per rising edge in RUN; no sweep in IDLE.

Source files
------------

// File: rtl/parallax_scroll_scheduler.sv
// Per-frame parallax scroll scheduler: on each vsync rising edge in RUN, sweeps
// all layer offsets one per clock through a shared add/wrap unit.
module parallax_scroll_scheduler #(
  parameter int NUM_LAYERS    = 3,
  parameter int OFFSET_W      = 10,
  parameter int SCROLL_PERIOD = 512,
  parameter int LEVEL_W       = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           vsync,
  input  logic                           start,
  input  logic                           pause_toggle,
  input  logic                           halt,
  input  logic [LEVEL_W-1:0]             level,
  output logic [NUM_LAYERS*OFFSET_W-1:0] layer_offset,
  output logic                           update_busy,
  output logic                           frame_done,
  output logic [1:0]                     state
);

  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [OFFSET_W:0] PERIOD = (OFFSET_W+1)'(SCROLL_PERIOD);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_LAYERS-1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t                         state_r, state_nxt;
  logic                           vsync_q;
  logic                           pending_pause, pending_nxt;
  logic [LEVEL_W-1:0]             level_q;
  logic [IDX_W-1:0]               idx;
  logic [NUM_LAYERS*OFFSET_W-1:0] offs_r;
  logic                           clear_offs;
  logic                           sweep_start;
  logic                           sweep_last;
  logic [OFFSET_W-1:0]            cur_off;
  logic [OFFSET_W:0]              sum;
  logic [OFFSET_W-1:0]            new_off;

  // Sum is one bit wider than an offset, so a single conditional subtract is a true modulo.
  function automatic logic [OFFSET_W-1:0] wrap_offset(input logic [OFFSET_W:0] s);
    logic [OFFSET_W:0] r;
    r = (s >= PERIOD) ? (s - PERIOD) : s;
    return r[OFFSET_W-1:0];
  endfunction

  assign cur_off = offs_r[idx*OFFSET_W +: OFFSET_W];
  assign sum     = {1'b0, cur_off} + (OFFSET_W+1)'(idx) + (OFFSET_W+1)'(1)
                 + (OFFSET_W+1)'(level_q);
  assign new_off = wrap_offset(sum);

  always_comb begin
    state_nxt   = state_r;
    pending_nxt = pending_pause;
    clear_offs  = 1'b0;
    case (state_r)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (halt) begin
          state_nxt   = HALTED;
          pending_nxt = 1'b0;
        end else if (pause_toggle && update_busy) begin
          pending_nxt = 1'b1;
        end else if (pause_toggle || (pending_pause && frame_done)) begin
          state_nxt   = PAUSED;
          pending_nxt = 1'b0;
        end
      end
      PAUSED: begin
        if (halt)              state_nxt = HALTED;
        else if (pause_toggle) state_nxt = RUN;
      end
      HALTED: begin
        if (!halt && start) begin
          state_nxt  = RUN;
          clear_offs = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A deferred pause blocks a new sweep until the state actually moves to PAUSED.
  assign sweep_start = vsync && !vsync_q && (state_r == RUN) && (state_nxt == RUN)
                     && !update_busy && !pending_pause;
  assign sweep_last  = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      vsync_q       <= 1'b0;
      pending_pause <= 1'b0;
      level_q       <= '0;
      idx           <= '0;
      offs_r        <= '0;
      update_busy   <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      vsync_q       <= vsync;
      pending_pause <= pending_nxt;
      frame_done    <= 1'b0;
      if (clear_offs) offs_r <= '0;
      if (sweep_start) begin
        update_busy <= 1'b1;
        idx         <= '0;
        level_q     <= level;
      end else if (update_busy) begin
        offs_r[idx*OFFSET_W +: OFFSET_W] <= new_off;
        idx <= idx + 1'b1;
        if (halt) begin
          update_busy <= 1'b0;
        end else if (sweep_last) begin
          update_busy <= 1'b0;
          frame_done  <= 1'b1;
        end
      end
    end
  end

  assign layer_offset = offs_r;
  assign state        = state_r;

endmodule

// File: tb/tb_parallax_scroll_scheduler.sv
// Directed bench for parallax_scroll_scheduler: frame table plus hand-written
// sequences for sweep timing, pause deferral, halt abort and edge handling.
module tb_parallax_scroll_scheduler;

  localparam int N  = 3;
  localparam int OW = 10;

  logic          clk = 1'b0;
  logic          reset, vsync, start, pause_toggle, halt;
  logic [1:0]    level;
  logic [N*OW-1:0] layer_offset;
  logic          update_busy, frame_done;
  logic [1:0]    state;

  int checks = 0;
  int failures = 0;

  parallax_scroll_scheduler #(
    .NUM_LAYERS(N), .OFFSET_W(OW), .SCROLL_PERIOD(512), .LEVEL_W(2)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .start(start),
    .pause_toggle(pause_toggle), .halt(halt), .level(level),
    .layer_offset(layer_offset), .update_busy(update_busy),
    .frame_done(frame_done), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] lvl;
    int         frames;
    int         e0, e1, e2;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int off(input int k);
    return int'(layer_offset[k*OW +: OW]);
  endfunction

  task automatic chk_offs(input string name, input int e0, input int e1, input int e2);
    chk({name, " off0"}, off(0), e0);
    chk({name, " off1"}, off(1), e1);
    chk({name, " off2"}, off(2), e2);
  endtask

  task automatic do_frame(input logic [1:0] lv);
    level = lv;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    repeat (N + 2) tick();
  endtask

  initial begin
    vecs[0] = '{2'd0, 169, 170, 340, 510};
    vecs[1] = '{2'd0,   1, 171, 342,   1};
    vecs[2] = '{2'd3,   1, 175, 347,   7};
    vecs[3] = '{2'd1,   2, 179, 353,  15};
    vecs[4] = '{2'd3,  40, 339,  41, 255};
    vecs[5] = '{2'd2,  50, 489, 241, 505};

    reset = 1'b1; vsync = 1'b0; start = 1'b0; pause_toggle = 1'b0;
    halt = 1'b0; level = 2'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_offs("reset", 0, 0, 0);
    chk("reset state", state, 0);
    chk("reset busy", update_busy, 0);
    chk("reset frame_done", frame_done, 0);

    start = 1'b1; tick(); start = 1'b0;
    chk("start state", state, 1);

    // First sweep with cycle-exact busy/frame_done timing
    level = 2'd0; vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk("E+1 busy", update_busy, 1);
    chk("E+1 frame_done", frame_done, 0);
    tick();
    chk("E+2 busy", update_busy, 1);
    tick();
    chk("E+3 busy", update_busy, 1);
    chk("E+3 frame_done", frame_done, 0);
    tick();
    chk("E+4 busy", update_busy, 0);
    chk("E+4 frame_done", frame_done, 1);
    tick();
    chk("E+5 frame_done", frame_done, 0);
    chk_offs("first frame", 1, 2, 3);

    foreach (vecs[i]) begin
      repeat (vecs[i].frames) do_frame(vecs[i].lvl);
      chk_offs($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2);
    end

    // Exact hit of the period wraps to zero
    do_frame(2'd1);
    chk_offs("pre exact", 491, 244, 509);
    do_frame(2'd0);
    chk_offs("exact wrap", 492, 246, 0);

    // Level changed mid-sweep must not affect this frame's speeds
    level = 2'd3; vsync = 1'b1;
    tick();
    vsync = 1'b0; level = 2'd0;
    repeat (N + 2) tick();
    chk_offs("level latch", 496, 251, 6);

    // Pause requested mid-sweep is deferred until after frame_done
    level = 2'd0; vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    pause_toggle = 1'b1;
    tick();
    pause_toggle = 1'b0;
    chk("pause E+3 state", state, 1);
    chk("pause E+3 busy", update_busy, 1);
    tick();
    chk("pause E+4 frame_done", frame_done, 1);
    chk("pause E+4 state", state, 1);
    tick();
    chk("pause E+5 state", state, 2);
    chk_offs("pause sweep", 497, 253, 9);
    do_frame(2'd0);
    chk_offs("paused edge", 497, 253, 9);
    pause_toggle = 1'b1; tick(); pause_toggle = 1'b0;
    chk("resume state", state, 1);
    do_frame(2'd0);
    chk_offs("resumed", 498, 255, 12);

    // Halt mid-sweep aborts: layers 0,1 written, layer 2 untouched
    level = 2'd0; vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    halt = 1'b1;
    tick();
    chk("halt busy", update_busy, 0);
    chk("halt state", state, 3);
    chk_offs("halt abort", 499, 257, 12);
    tick();
    chk("halt no frame_done", frame_done, 0);
    do_frame(2'd0);
    chk_offs("halted edge", 499, 257, 12);
    start = 1'b1; tick(); start = 1'b0;
    chk("start while halt", state, 3);
    halt = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("restart state", state, 1);
    chk_offs("restart clear", 0, 0, 0);

    // vsync held high gives exactly one sweep
    level = 2'd0; vsync = 1'b1;
    repeat (10) tick();
    vsync = 1'b0;
    repeat (3) tick();
    chk_offs("held vsync", 1, 2, 3);

    // Second edge during a sweep is ignored
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    repeat (5) tick();
    chk_offs("edge in sweep", 2, 4, 6);
    chk("edge in sweep busy", update_busy, 0);

    // Edge coinciding with halt in RUN: no sweep
    vsync = 1'b1; halt = 1'b1;
    tick();
    vsync = 1'b0;
    chk("edge+halt state", state, 3);
    chk("edge+halt busy", update_busy, 0);
    repeat (4) tick();
    chk_offs("edge+halt", 2, 4, 6);
    halt = 1'b0;

    // Edge in IDLE after reset
    reset = 1'b1; tick(); reset = 1'b0;
    chk("re-reset state", state, 0);
    chk_offs("re-reset", 0, 0, 0);
    do_frame(2'd2);
    chk_offs("idle edge", 0, 0, 0);
    chk("idle busy", update_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
